// File: rtl/mem_cmd_splitter_pkg.sv
// Shared command widths, default boundary and FSM state type for the command splitter.
package mem_cmd_splitter_pkg;

  localparam int ADDR_W             = 64;
  localparam int LEN_W              = 32;
  localparam int DEF_BOUNDARY_BYTES = 4096;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_cmd_splitter_rr_arbiter.sv
// Round-robin arbiter: picks the lowest requesting index at or after ptr, wrapping to index 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic          hi_hit;
  logic          lo_hit;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_hit = 1'b1;
        lo_idx = IW'(i);
        if (i >= int'(ptr)) begin
          hi_hit = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
  end

  assign index = hi_hit ? hi_idx : lo_idx;
  assign grant = lo_hit ? (N'(1) << index) : '0;

endmodule

// File: rtl/mem_cmd_splitter.sv
// Splits per-channel memory commands into chunks bounded by a max burst size and an
// address boundary; one command in flight, chunks emitted one per cycle under ready.
module mem_cmd_splitter
  import mem_cmd_splitter_pkg::*;
#(
  parameter int NUM_CHANNELS    = 2,
  parameter int CH_WIDTH        = 1,
  parameter int MAX_BURST_BYTES = 4096,
  parameter int BOUNDARY_BYTES  = DEF_BOUNDARY_BYTES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CHANNELS-1:0]        s_cmd_valid,
  output logic [NUM_CHANNELS-1:0]        s_cmd_ready,
  input  logic [NUM_CHANNELS*ADDR_W-1:0] s_cmd_address,
  input  logic [NUM_CHANNELS*LEN_W-1:0]  s_cmd_length,
  output logic                           m_cmd_valid,
  input  logic                           m_cmd_ready,
  output logic [ADDR_W-1:0]              m_cmd_address,
  output logic [LEN_W-1:0]               m_cmd_length,
  output logic [CH_WIDTH-1:0]            m_cmd_dest,
  output logic                           m_cmd_last,
  output logic                           busy
);

  localparam logic [ADDR_W:0]   BOUND_W = (ADDR_W + 1)'(BOUNDARY_BYTES);
  localparam logic [ADDR_W:0]   MAX_W   = (ADDR_W + 1)'(MAX_BURST_BYTES);
  localparam logic [ADDR_W-1:0] BMASK   = ADDR_W'(BOUNDARY_BYTES - 1);

  // Wide arithmetic so a full 32-bit remaining count never truncates against the limits.
  function automatic logic [LEN_W-1:0] chunk_len(input logic [ADDR_W-1:0] addr,
                                                 input logic [LEN_W-1:0]  rem);
    logic [ADDR_W:0] room;
    logic [ADDR_W:0] lim;
    room = BOUND_W - {1'b0, addr & BMASK};
    lim  = (room < MAX_W) ? room : MAX_W;
    if ({{(ADDR_W + 1 - LEN_W){1'b0}}, rem} < lim) return rem;
    else return lim[LEN_W-1:0];
  endfunction

  state_e                  state_q, state_d;
  logic [CH_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic                    m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]       m_addr_q, m_addr_d;
  logic [LEN_W-1:0]        m_len_q, m_len_d;
  logic [CH_WIDTH-1:0]     m_dest_q, m_dest_d;
  logic                    m_last_q, m_last_d;

  logic [NUM_CHANNELS-1:0] gnt;
  logic [CH_WIDTH-1:0]     gnt_idx;
  logic [NUM_CHANNELS-1:0] s_ready;
  logic [ADDR_W-1:0]       sel_addr;
  logic [LEN_W-1:0]        sel_length;
  logic [LEN_W-1:0]        sel_chunk;
  logic [ADDR_W-1:0]       nxt_addr;
  logic [LEN_W-1:0]        nxt_rem;
  logic [LEN_W-1:0]        nxt_chunk;

  rr_arbiter #(
    .N  (NUM_CHANNELS),
    .IW (CH_WIDTH)
  ) u_arb (
    .req   (s_cmd_valid),
    .ptr   (rr_ptr_q),
    .grant (gnt),
    .index (gnt_idx)
  );

  always_comb begin
    sel_addr   = '0;
    sel_length = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (gnt[i]) begin
        sel_addr   = s_cmd_address[i*ADDR_W +: ADDR_W];
        sel_length = s_cmd_length[i*LEN_W +: LEN_W];
      end
    end
  end

  assign sel_chunk = chunk_len(sel_addr, sel_length);
  assign nxt_addr  = m_addr_q + ADDR_W'(m_len_q);
  assign nxt_rem   = rem_q - m_len_q;
  assign nxt_chunk = chunk_len(nxt_addr, nxt_rem);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    rem_d     = rem_q;
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_len_d   = m_len_q;
    m_dest_d  = m_dest_q;
    m_last_d  = m_last_q;
    s_ready   = '0;
    case (state_q)
      ST_IDLE: begin
        s_ready = gnt;
        if (|gnt) begin
          rr_ptr_d = (gnt_idx == CH_WIDTH'(NUM_CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
          if (sel_length != '0) begin
            state_d   = ST_SPLIT;
            m_valid_d = 1'b1;
            m_addr_d  = sel_addr;
            m_len_d   = sel_chunk;
            m_dest_d  = gnt_idx;
            m_last_d  = (sel_chunk == sel_length);
            rem_d     = sel_length;
          end
        end
      end
      ST_SPLIT: begin
        if (m_cmd_ready) begin
          if (m_last_q) begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
          end else begin
            m_addr_d = nxt_addr;
            m_len_d  = nxt_chunk;
            m_last_d = (nxt_chunk == nxt_rem);
            rem_d    = nxt_rem;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      rem_q     <= '0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_len_q   <= '0;
      m_dest_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      rem_q     <= rem_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_len_q   <= m_len_d;
      m_dest_q  <= m_dest_d;
      m_last_q  <= m_last_d;
    end
  end

  assign s_cmd_ready   = rst ? '0 : s_ready;
  assign m_cmd_valid   = m_valid_q;
  assign m_cmd_address = m_addr_q;
  assign m_cmd_length  = m_len_q;
  assign m_cmd_dest    = m_dest_q;
  assign m_cmd_last    = m_last_q;
  assign busy          = (state_q == ST_SPLIT);

endmodule

// File: tb/tb_mem_cmd_splitter.sv
// Directed self-checking bench for mem_cmd_splitter with default parameters.
module tb_mem_cmd_splitter;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   s_cmd_valid;
  logic [N-1:0]   s_cmd_ready;
  logic [N*64-1:0] s_cmd_address;
  logic [N*32-1:0] s_cmd_length;
  logic           m_cmd_valid;
  logic           m_cmd_ready;
  logic [63:0]    m_cmd_address;
  logic [31:0]    m_cmd_length;
  logic [0:0]     m_cmd_dest;
  logic           m_cmd_last;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_cmd_splitter #(
    .NUM_CHANNELS    (2),
    .CH_WIDTH        (1),
    .MAX_BURST_BYTES (4096),
    .BOUNDARY_BYTES  (4096)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_cmd_valid   (s_cmd_valid),
    .s_cmd_ready   (s_cmd_ready),
    .s_cmd_address (s_cmd_address),
    .s_cmd_length  (s_cmd_length),
    .m_cmd_valid   (m_cmd_valid),
    .m_cmd_ready   (m_cmd_ready),
    .m_cmd_address (m_cmd_address),
    .m_cmd_length  (m_cmd_length),
    .m_cmd_dest    (m_cmd_dest),
    .m_cmd_last    (m_cmd_last),
    .busy          (busy)
  );

  typedef struct {
    int          ch;
    logic [63:0] addr;
    logic [31:0] len;
    int          n;
    logic [63:0] ea[3];
    logic [31:0] el[3];
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input int ch, input logic [63:0] a, input logic [31:0] l);
    s_cmd_address[ch*64 +: 64] = a;
    s_cmd_length[ch*32 +: 32]  = l;
    s_cmd_valid[ch]            = 1'b1;
  endtask

  // Leaves time at edge+2 of the grant cycle; caller ticks to complete the handshake.
  task automatic wait_grant(input int ch);
    int w;
    w = 0;
    #1;
    while (!s_cmd_ready[ch] && w < 20) begin
      @(posedge clk);
      #2;
      w++;
    end
    check("grant_onehot", 64'(s_cmd_ready), 64'(1) << ch);
  endtask

  task automatic set_vec(input int i, input int ch, input logic [63:0] a, input logic [31:0] l,
                         input int n, input logic [63:0] a0, input logic [31:0] l0,
                         input logic [63:0] a1, input logic [31:0] l1,
                         input logic [63:0] a2, input logic [31:0] l2);
    vecs[i].ch = ch; vecs[i].addr = a; vecs[i].len = l; vecs[i].n = n;
    vecs[i].ea[0] = a0; vecs[i].el[0] = l0;
    vecs[i].ea[1] = a1; vecs[i].el[1] = l1;
    vecs[i].ea[2] = a2; vecs[i].el[2] = l2;
  endtask

  task automatic zero_len(input int ch, output int pulses, output int vseen);
    pulses = 0;
    vseen  = 0;
    drive_cmd(ch, 64'h0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      #1;
      if (s_cmd_ready[ch]) pulses++;
      if (m_cmd_valid) vseen++;
      @(posedge clk);
      #1;
      if (pulses > 0) s_cmd_valid[ch] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          got, cyc, pulses, vseen;
    logic [0:0]  dests[4];
    logic [63:0] sv_addr;
    logic [31:0] sv_len;
    logic        sv_last, prev_stall, done;
    logic [63:0] sum;
    logic [63:0] bp_a[3];
    logic [31:0] bp_l[3];

    set_vec(0, 0, 64'h1000, 32'h2400, 3, 64'h1000, 32'h1000, 64'h2000, 32'h1000, 64'h3000, 32'h400);
    set_vec(1, 0, 64'h0FC0, 32'h80, 2, 64'h0FC0, 32'h40, 64'h1000, 32'h40, 64'h0, 32'h0);
    set_vec(2, 1, 64'hFFFF_FFFF_FFFF_F800, 32'h1000, 2, 64'hFFFF_FFFF_FFFF_F800, 32'h800,
            64'h0, 32'h800, 64'h0, 32'h0);
    set_vec(3, 1, 64'h10, 32'h20, 1, 64'h10, 32'h20, 64'h0, 32'h0, 64'h0, 32'h0);
    set_vec(4, 0, 64'h0, 32'h3000, 3, 64'h0, 32'h1000, 64'h1000, 32'h1000, 64'h2000, 32'h1000);
    set_vec(5, 1, 64'h1234, 32'h100, 1, 64'h1234, 32'h100, 64'h0, 32'h0, 64'h0, 32'h0);
    set_vec(6, 0, 64'h100, 32'h1F00, 2, 64'h100, 32'hF00, 64'h1000, 32'h1000, 64'h0, 32'h0);

    rst = 1'b1;
    s_cmd_valid = '0;
    s_cmd_address = '0;
    s_cmd_length = '0;
    m_cmd_ready = 1'b1;
    tick();
    tick();
    drive_cmd(0, 64'h40, 32'h40);
    #1;
    check("rst_s_ready", 64'(s_cmd_ready), 64'h0);
    check("rst_m_valid", 64'(m_cmd_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_m_addr", m_cmd_address, 64'h0);
    check("rst_m_len", 64'(m_cmd_length), 64'h0);
    check("rst_m_last", 64'(m_cmd_last), 64'h0);
    tick();
    s_cmd_valid = '0;
    rst = 1'b0;

    // Table-driven single commands with a always-ready sink.
    for (int v = 0; v < 7; v++) begin
      drive_cmd(vecs[v].ch, vecs[v].addr, vecs[v].len);
      wait_grant(vecs[v].ch);
      tick();
      s_cmd_valid = '0;
      #1;
      check("latency_valid", 64'(m_cmd_valid), 64'h1);
      check("busy_split", 64'(busy), 64'h1);
      check("s_ready_in_split", 64'(s_cmd_ready), 64'h0);
      for (int k = 0; k < vecs[v].n; k++) begin
        check("chunk_valid", 64'(m_cmd_valid), 64'h1);
        check("chunk_addr", m_cmd_address, vecs[v].ea[k]);
        check("chunk_len", 64'(m_cmd_length), 64'(vecs[v].el[k]));
        check("chunk_last", 64'(m_cmd_last), (k == vecs[v].n - 1) ? 64'h1 : 64'h0);
        check("chunk_dest", 64'(m_cmd_dest), 64'(vecs[v].ch));
        tick();
        #1;
      end
      check("end_valid", 64'(m_cmd_valid), 64'h0);
      check("end_busy", 64'(busy), 64'h0);
    end

    // Round robin with both channels continuously requesting, from rr_ptr = 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_cmd(0, 64'h0, 32'h40);
    drive_cmd(1, 64'h40, 32'h40);
    got = 0;
    cyc = 0;
    #1;
    while (got < 4 && cyc < 40) begin
      if (m_cmd_valid) begin
        dests[got] = m_cmd_dest;
        check("rr_last", 64'(m_cmd_last), 64'h1);
        check("rr_len", 64'(m_cmd_length), 64'h40);
        got++;
        if (got == 4) s_cmd_valid = '0;
      end
      tick();
      #1;
      cyc++;
    end
    check("rr_count", 64'(got), 64'd4);
    for (int i = 0; i < 4; i++) check("rr_dest", 64'(dests[i]), 64'(i % 2));

    // Zero-length commands: one ready pulse, no output, pointer still advances.
    tick();
    zero_len(0, pulses, vseen);
    check("zl0_pulses", 64'(pulses), 64'd1);
    check("zl0_no_valid", 64'(vseen), 64'd0);
    zero_len(1, pulses, vseen);
    check("zl1_pulses", 64'(pulses), 64'd1);
    check("zl1_no_valid", 64'(vseen), 64'd0);
    drive_cmd(0, 64'h80, 32'h40);
    drive_cmd(1, 64'hC0, 32'h40);
    #1;
    check("zl_next_grant", 64'(s_cmd_ready), 64'h1);
    tick();
    s_cmd_valid = '0;
    #1;
    check("zl_chunk_valid", 64'(m_cmd_valid), 64'h1);
    check("zl_chunk_dest", 64'(m_cmd_dest), 64'h0);
    check("zl_chunk_addr", m_cmd_address, 64'h80);
    tick();
    #1;
    check("zl_end_valid", 64'(m_cmd_valid), 64'h0);

    // Backpressure: five stalled cycles on the second chunk.
    bp_a[0] = 64'h800;  bp_l[0] = 32'h800;
    bp_a[1] = 64'h1000; bp_l[1] = 32'h1000;
    bp_a[2] = 64'h2000; bp_l[2] = 32'h1000;
    tick();
    drive_cmd(0, 64'h800, 32'h2800);
    wait_grant(0);
    tick();
    s_cmd_valid = '0;
    got = 0;
    sum = '0;
    prev_stall = 1'b0;
    done = 1'b0;
    sv_addr = '0;
    sv_len = '0;
    sv_last = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      m_cmd_ready = (c >= 1 && c <= 5) ? 1'b0 : 1'b1;
      #1;
      if (prev_stall) begin
        check("bp_hold_valid", 64'(m_cmd_valid), 64'h1);
        check("bp_hold_addr", m_cmd_address, sv_addr);
        check("bp_hold_len", 64'(m_cmd_length), 64'(sv_len));
        check("bp_hold_last", 64'(m_cmd_last), 64'(sv_last));
      end
      if (m_cmd_valid) begin
        sv_addr = m_cmd_address;
        sv_len  = m_cmd_length;
        sv_last = m_cmd_last;
        if (m_cmd_ready && got < 3) begin
          check("bp_addr", m_cmd_address, bp_a[got]);
          check("bp_len", 64'(m_cmd_length), 64'(bp_l[got]));
          sum = sum + 64'(m_cmd_length);
          got++;
          if (m_cmd_last) done = 1'b1;
        end
      end
      prev_stall = m_cmd_valid && !m_cmd_ready;
      tick();
    end
    m_cmd_ready = 1'b1;
    #1;
    check("bp_chunks", 64'(got), 64'd3);
    check("bp_sum", sum, 64'h2800);
    check("bp_end_valid", 64'(m_cmd_valid), 64'h0);

    // Reset during the second chunk of a three-chunk command.
    tick();
    drive_cmd(0, 64'h0, 32'h3000);
    wait_grant(0);
    tick();
    s_cmd_valid = '0;
    #1;
    check("mr_chunk0_addr", m_cmd_address, 64'h0);
    tick();
    #1;
    check("mr_chunk1_addr", m_cmd_address, 64'h1000);
    rst = 1'b1;
    tick();
    drive_cmd(1, 64'h40, 32'h40);
    #1;
    check("mr_valid", 64'(m_cmd_valid), 64'h0);
    check("mr_busy", 64'(busy), 64'h0);
    check("mr_s_ready", 64'(s_cmd_ready), 64'h0);
    check("mr_m_len", 64'(m_cmd_length), 64'h0);
    rst = 1'b0;
    #1;
    check("mr_new_grant", 64'(s_cmd_ready), 64'h2);
    tick();
    s_cmd_valid = '0;
    #1;
    check("mr_new_valid", 64'(m_cmd_valid), 64'h1);
    check("mr_new_addr", m_cmd_address, 64'h40);
    check("mr_new_len", 64'(m_cmd_length), 64'h40);
    check("mr_new_dest", 64'(m_cmd_dest), 64'h1);
    check("mr_new_last", 64'(m_cmd_last), 64'h1);
    tick();
    #1;
    check("mr_no_stale", 64'(m_cmd_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
